// File: rtl/mod_counter_if.sv
// Control/status bundle for mod_counter: control strobes in, count and flags out.
// master drives the controls, slave is the counter itself.
interface mod_counter_if #(
  parameter int WIDTH = 8
);
  logic             EN;
  logic             UP;
  logic             SAT;
  logic             LOAD;
  logic [WIDTH-1:0] LOAD_VAL;
  logic [WIDTH-1:0] COUNT;
  logic             TC;
  logic             OVF;

  modport master (
    output EN, UP, SAT, LOAD, LOAD_VAL,
    input  COUNT, TC, OVF
  );

  modport slave (
    input  EN, UP, SAT, LOAD, LOAD_VAL,
    output COUNT, TC, OVF
  );
endinterface

// File: rtl/mod_counter.sv
// Up/down modulus counter 0..MAX with prescaler, wrap/saturate, parallel load, TC pulse, sticky OVF.
// Latency: COUNT/TC/OVF registered, update on the edge after the tick or load.
// Backpressure: none; EN freezes the prescaler, LOAD overrides any coincident tick.
module mod_counter #(
  parameter int WIDTH    = 8,
  parameter int MAX      = 15,
  parameter int PRESCALE = 1
) (
  input  logic          CLK,
  input  logic          RST,
  mod_counter_if.slave  bus
);

  localparam int               PSW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSW-1:0]   PS_LAST = PSW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PSW-1:0]   ps_q, ps_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             tick;

  assign tick      = bus.EN && (ps_q == PS_LAST);
  assign bus.COUNT = count_q;
  assign bus.TC    = tc_q;
  assign bus.OVF   = ovf_q;

  always_comb begin
    count_d = count_q;
    ps_d    = ps_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (bus.LOAD) begin
      // Out-of-range load values clamp so COUNT never exceeds MAX.
      count_d = (bus.LOAD_VAL > MAX_V) ? MAX_V : bus.LOAD_VAL;
      ps_d    = '0;
      ovf_d   = 1'b0;
    end else if (bus.EN) begin
      ps_d = tick ? '0 : ps_q + PSW'(1);
      if (tick) begin
        if (bus.UP) begin
          if (count_q == MAX_V) begin
            tc_d    = 1'b1;
            ovf_d   = 1'b1;
            count_d = bus.SAT ? MAX_V : '0;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end else begin
          if (count_q == '0) begin
            tc_d    = 1'b1;
            ovf_d   = 1'b1;
            count_d = bus.SAT ? '0 : MAX_V;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
      ps_q    <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ps_q    <= ps_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter across three parameter sets with directed and random stimulus.
module tb_mod_counter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mod_counter_if #(.WIDTH(8)) bus_a ();
  mod_counter_if #(.WIDTH(4)) bus_b ();
  mod_counter_if #(.WIDTH(4)) bus_c ();

  mod_counter #(.WIDTH(8), .MAX(15), .PRESCALE(1)) dut_a (.CLK(clk), .RST(rst), .bus(bus_a));
  mod_counter #(.WIDTH(4), .MAX(9),  .PRESCALE(4)) dut_b (.CLK(clk), .RST(rst), .bus(bus_b));
  mod_counter #(.WIDTH(4), .MAX(15), .PRESCALE(2)) dut_c (.CLK(clk), .RST(rst), .bus(bus_c));

  // Reference model: per-instance count, enabled cycles since last restart, sticky flag.
  int MAXV [3] = '{15, 9, 15};
  int PSV  [3] = '{1, 4, 2};
  int WV   [3] = '{8, 4, 4};
  int m_cnt[3];
  int m_en [3];
  bit m_ovf[3];

  logic [9:0] q0[$];
  logic [9:0] q1[$];
  logic [9:0] q2[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic push(input int i, input logic [9:0] v);
    case (i)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic model_step(input int i, input bit r, input bit e, input bit u,
                            input bit s, input bit l, input logic [7:0] lv);
    int lvm;
    bit tc;
    lvm = (WV[i] == 8) ? int'(lv) : int'(lv) % 16;
    tc  = 1'b0;
    if (r) begin
      m_cnt[i] = 0; m_en[i] = 0; m_ovf[i] = 1'b0;
    end else if (l) begin
      m_cnt[i] = (lvm > MAXV[i]) ? MAXV[i] : lvm;
      m_en[i]  = 0;
      m_ovf[i] = 1'b0;
    end else if (e) begin
      m_en[i]++;
      if (m_en[i] % PSV[i] == 0) begin
        if (u) begin
          if (m_cnt[i] == MAXV[i]) begin
            tc = 1'b1; m_ovf[i] = 1'b1;
            m_cnt[i] = s ? MAXV[i] : 0;
          end else begin
            m_cnt[i] = (m_cnt[i] + 1) % (MAXV[i] + 1);
          end
        end else begin
          if (m_cnt[i] == 0) begin
            tc = 1'b1; m_ovf[i] = 1'b1;
            m_cnt[i] = s ? 0 : MAXV[i];
          end else begin
            m_cnt[i] = m_cnt[i] - 1;
          end
        end
      end
    end
    push(i, {m_ovf[i], tc, 8'(m_cnt[i])});
  endtask

  task automatic drive(input bit r, input bit e, input bit u, input bit s,
                       input bit l, input logic [7:0] lv);
    rst = r;
    bus_a.EN = e; bus_a.UP = u; bus_a.SAT = s; bus_a.LOAD = l; bus_a.LOAD_VAL = lv;
    bus_b.EN = e; bus_b.UP = u; bus_b.SAT = s; bus_b.LOAD = l; bus_b.LOAD_VAL = lv[3:0];
    bus_c.EN = e; bus_c.UP = u; bus_c.SAT = s; bus_c.LOAD = l; bus_c.LOAD_VAL = lv[3:0];
    for (int i = 0; i < 3; i++) model_step(i, r, e, u, s, l, lv);
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n, input bit e, input bit u, input bit s);
    for (int k = 0; k < n; k++) drive(1'b0, e, u, s, 1'b0, 8'd0);
  endtask

  task automatic check(input int i, input logic [9:0] act);
    logic [9:0] exp;
    bit have;
    have = 1'b0;
    exp  = '0;
    case (i)
      0: if (q0.size() > 0) begin exp = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin exp = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin exp = q2.pop_front(); have = 1'b1; end
    endcase
    if (have) begin
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL inst%0d cycle %0d: count %0d tc %b ovf %b, expected count %0d tc %b ovf %b",
                 i, cyc, act[7:0], act[8], act[9], exp[7:0], exp[8], exp[9]);
      end
    end
  endtask

  // Monitor: every edge presents a fresh registered output, sampled 1 time unit later.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      check(0, {bus_a.OVF, bus_a.TC, bus_a.COUNT});
      check(1, {bus_b.OVF, bus_b.TC, 4'b0, bus_b.COUNT});
      check(2, {bus_c.OVF, bus_c.TC, 4'b0, bus_c.COUNT});
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_en[i] = 0; m_ovf[i] = 1'b0;
    end
    drive(1, 0, 1, 0, 0, 8'd0);
    drive(1, 0, 1, 0, 0, 8'd0);
    run(20, 1, 1, 0);                 // wrap up-count
    drive(1, 0, 1, 0, 0, 8'd0);
    run(20, 1, 0, 0);                 // wrap down-count through 0 -> MAX
    drive(1, 0, 1, 0, 0, 8'd0);
    run(40, 1, 1, 1);                 // saturate at MAX
    drive(0, 0, 1, 0, 1, 8'd200);     // clamped load clears OVF
    run(3, 0, 1, 0);
    run(5, 1, 1, 0);
    drive(0, 1, 1, 0, 1, 8'd7);       // load with coincident tick
    run(12, 1, 1, 0);
    drive(1, 0, 1, 0, 0, 8'd0);
    run(6, 1, 1, 0);
    run(3, 0, 1, 0);                  // EN gap mid-period
    run(10, 1, 1, 0);
    drive(1, 0, 1, 0, 0, 8'd0);
    run(43, 1, 1, 0);
    drive(1, 1, 1, 0, 0, 8'd0);       // reset mid-count / mid-prescale
    run(10, 1, 1, 0);
    drive(1, 0, 1, 0, 0, 8'd0);
    run(30, 1, 0, 1);                 // saturate at 0
    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(63) == 0, $urandom_range(3) != 0, 1'($urandom_range(1)),
            1'($urandom_range(1)), $urandom_range(15) == 0, 8'($urandom_range(255)));
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0",
               q0.size() + q1.size() + q2.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised modulus counter generalising the board's fixed 0–15 binary counter. Counts up or down between 0 and a configurable terminal value MAX, advancing once every PRESCALE enabled clock cycles. Supports wrap or saturate mode, synchronous parallel load, a one-cycle terminal-count pulse and a sticky overflow flag. Output drives the 7-segment/LED display path or chains into further counter stages via TC.

## Interface
Parameters:
- WIDTH, 8, bit width of COUNT and LOAD_VAL.
- MAX, 15, terminal count; legal range 1 ≤ MAX ≤ 2^WIDTH−1.
- PRESCALE, 1, enabled CLK cycles per count step; legal range ≥1. The value 1 steps on every enabled cycle.

Ports:
- CLK  in  1  single system clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  count enable; gates the prescaler.
- UP  in  1  direction: 1 = increment, 0 = decrement.
- SAT  in  1  mode: 1 = saturate at the boundary, 0 = wrap.
- LOAD  in  1  synchronous parallel load strobe.
- LOAD_VAL  in  WIDTH  value to load.
- COUNT  out  WIDTH  current count, registered.
- TC  out  1  terminal-count pulse, registered, one cycle wide.
- OVF  out  1  sticky flag set on any wrap or saturate event.

## Operation
- Internal prescaler PS, width max(1, clog2(PRESCALE)), runs 0..PRESCALE−1.
- tick = EN & (PS == PRESCALE−1).
- While EN=1, PS increments each cycle and returns to 0 after PRESCALE−1.
- While EN=0, PS holds its value and no tick occurs.
- Per-edge priority: RST > LOAD > tick > hold.
- RST: COUNT=0, PS=0, TC=0, OVF=0.
- LOAD, regardless of EN:
  - COUNT = min(LOAD_VAL, MAX), so out-of-range values clamp to MAX.
  - PS=0, TC=0, OVF=0.
  - A tick coincident with LOAD is discarded.
- Tick with UP=1:
  - COUNT<MAX: COUNT+1.
  - COUNT==MAX and SAT=0: COUNT=0, TC=1, OVF=1.
  - COUNT==MAX and SAT=1: COUNT holds at MAX, TC=1, OVF=1.
- Tick with UP=0:
  - COUNT>0: COUNT−1.
  - COUNT==0 and SAT=0: COUNT=MAX, TC=1, OVF=1.
  - COUNT==0 and SAT=1: COUNT holds at 0, TC=1, OVF=1.
- TC is 0 on every cycle not described above.
- In saturate mode, TC re-pulses on every tick spent at the boundary.
- Invariant: COUNT ≤ MAX at all times.
- Arithmetic is done at WIDTH bits. MAX = 2^WIDTH−1 must wrap correctly with no overflow into an extra bit.
- UP and SAT are sampled only on tick edges. Changing them between ticks affects only the next step.
- OVF clears only on RST or LOAD.

## Timing
- Reset values: COUNT=0, TC=0, OVF=0. PS=0 internally.
- First step after EN rises, with PS=0: COUNT changes on the PRESCALE-th rising edge with EN=1.
- Steady state: one step every PRESCALE enabled cycles.
- TC and OVF are registered and update on the same edge as the wrapping/saturating COUNT update. TC is high for exactly one cycle.
- LOAD: COUNT shows the loaded value the cycle after the LOAD edge. The next tick follows PRESCALE enabled cycles later.
- RST mid-count or mid-prescale: all state clears on that edge. Counting restarts from PS=0.
- EN dropped mid-prescale: PS freezes. When EN returns, the remaining cycles of the period complete first, then the step occurs.
- PRESCALE=1, EN held high: COUNT steps every cycle. TC is high on the cycle COUNT shows 0 after MAX.

## Test plan
- Default params, RST then EN=1, UP=1, SAT=0 for 20 cycles:
  - COUNT 0,1,…,15,0,1,2,3.
  - TC high only on the cycle COUNT returns to 0.
  - OVF rises on that same cycle and stays high.
- UP=0 from reset, SAT=0: COUNT 0→15→14…; TC and OVF assert on the 0→15 step.
- SAT=1, UP=1, 18 ticks: COUNT reaches 15 and holds. TC pulses on each tick at 15. COUNT is never 0.
- LOAD_VAL=200 with MAX=15: COUNT=15 next cycle and OVF clears. LOAD_VAL=7 together with a tick: COUNT=7, the tick is ignored, and the next step goes to 8 after PRESCALE cycles.
- PRESCALE=4, WIDTH=4, MAX=9:
  - COUNT steps every 4 cycles.
  - Dropping EN for 3 cycles mid-period delays the step by exactly 3 cycles.
  - Count sequence wraps 9→0.
- RST asserted while COUNT=11 and PS mid-period: next cycle COUNT=0, TC=0, OVF=0. The first step after release occurs PRESCALE enabled cycles later.
